// File: rtl/dec_pkg.sv
// Shared constants, run-state enum and a width helper for the one-hot
// decoder block and its prescaler.
package dec_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT_RUN,
    SCAN_RUN
  } run_state_e;

  // Number of bits needed to count values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_onehot_decoder_if.sv
// Control and status bundle of the sequential one-hot decoder.
// The controller uses the master modport; the decoder uses the slave modport.
interface seq_onehot_decoder_if #(
  parameter int N = 3
);

  localparam int W = 1 << N;

  logic         en;
  logic         mode;
  logic         dir;
  logic         load;
  logic [N-1:0] a;
  logic [W-1:0] d;
  logic [N-1:0] idx;
  logic         wrap;

  modport master (
    output en, mode, dir, load, a,
    input  d, idx, wrap
  );

  modport slave (
    input  en, mode, dir, load, a,
    output d, idx, wrap
  );

endinterface

// File: rtl/seq_onehot_decoder_tick_prescaler.sv
// Free-running modulo-PRESCALE counter with synchronous clear and enable.
// tick is high for one cycle in the cycle where an enabled counter reaches its last count.
module tick_prescaler
  import dec_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // clear wins over counting, so a load can never produce a tick in its own cycle
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered N-to-2**N one-hot decoder with an index register, DIRECT load mode
// and SCAN mode that steps the index up or down every PRESCALE cycles with wrap-around.
module seq_onehot_decoder
  import dec_pkg::*;
#(
  parameter int N          = 3,
  parameter int PRESCALE   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_onehot_decoder_if.slave  bus
);

  localparam int W = 1 << N;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [W-1:0] INACTIVE = {W{POL}};

  run_state_e   cur_state;
  logic         step;
  logic         presc_clear;
  logic         presc_enable;

  logic [N-1:0] idx_q,  idx_d;
  logic [W-1:0] d_q,    d_d;
  logic         wrap_q, wrap_d;

  // The run state follows en/mode directly, so a mode change acts in the same cycle.
  always_comb begin
    if (!bus.en) begin
      cur_state = IDLE;
    end else if (bus.mode == MODE_SCAN) begin
      cur_state = SCAN_RUN;
    end else begin
      cur_state = DIRECT_RUN;
    end
  end

  assign presc_clear  = bus.load || (cur_state == DIRECT_RUN);
  assign presc_enable = (cur_state == SCAN_RUN);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (presc_clear),
    .enable (presc_enable),
    .tick   (step)
  );

  // d is decoded from idx_d rather than idx_q so output and index always agree.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      idx_d = bus.a;
    end else if (cur_state == SCAN_RUN && step) begin
      if (bus.dir == DIR_UP) begin
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == {N{1'b1}});
      end else begin
        idx_d  = idx_q - 1'b1;
        wrap_d = (idx_q == {N{1'b0}});
      end
    end
    if (cur_state != IDLE) begin
      d_d = (W'(1) << idx_d) ^ INACTIVE;
    end else begin
      d_d = INACTIVE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      d_q    <= INACTIVE;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      d_q    <= d_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.idx  = idx_q;
  assign bus.d    = d_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Directed self-checking bench for seq_onehot_decoder: one active-high build
// with PRESCALE=4 and one ACTIVE_LOW build sharing clock and reset.
module tb_seq_onehot_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_onehot_decoder_if #(.N(3)) bus ();
  seq_onehot_decoder_if #(.N(3)) low_bus ();

  seq_onehot_decoder #(.N(3), .PRESCALE(4), .ACTIVE_LOW(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_onehot_decoder #(.N(3), .PRESCALE(4), .ACTIVE_LOW(1)) dut_low (
    .clk (clk),
    .rst (rst),
    .bus (low_bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 0; bus.mode = 0; bus.dir = 0; bus.load = 0; bus.a = '0;
    low_bus.en = 0; low_bus.mode = 0; low_bus.dir = 0; low_bus.load = 0; low_bus.a = '0;
    tick();
    tick();
    checks++;
    if (bus.d !== 8'h00) begin failures++; $display("[TB] FAIL reset_d got=%h exp=%h", bus.d, 8'h00); end
    checks++;
    if (bus.idx !== 3'd0) begin failures++; $display("[TB] FAIL reset_idx got=%0d exp=0", bus.idx); end
    checks++;
    if (bus.wrap !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap got=%b exp=0", bus.wrap); end
    checks++;
    if (low_bus.d !== 8'hFF) begin failures++; $display("[TB] FAIL reset_low_d got=%h exp=%h", low_bus.d, 8'hFF); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_direct_sweep();
    logic [7:0] exp_d [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    bus.en = 1; bus.mode = 0;
    for (int i = 0; i < 8; i++) begin
      bus.load = 1; bus.a = 3'(i);
      tick();
      bus.load = 0;
      checks++;
      if (bus.d !== exp_d[i]) begin failures++; $display("[TB] FAIL direct_d[%0d] got=%h exp=%h", i, bus.d, exp_d[i]); end
      checks++;
      if (bus.idx !== 3'(i)) begin failures++; $display("[TB] FAIL direct_idx[%0d] got=%0d exp=%0d", i, bus.idx, i); end
    end
    tick();
    checks++;
    if (bus.d !== 8'h80) begin failures++; $display("[TB] FAIL direct_hold_d got=%h exp=%h", bus.d, 8'h80); end
  endtask

  task automatic test_scan_up();
    logic [2:0] exp_idx  [3] = '{3'd7, 3'd0, 3'd1};
    logic       exp_wrap [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] exp_d    [3] = '{8'h80, 8'h01, 8'h02};
    logic [2:0] prev = 3'd6;
    bus.en = 1; bus.mode = 1; bus.dir = 0; bus.load = 1; bus.a = 3'd6;
    tick();
    bus.load = 0;
    checks++;
    if (bus.d !== 8'h40) begin failures++; $display("[TB] FAIL scan_up_load_d got=%h exp=%h", bus.d, 8'h40); end
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        if (k == 0) begin
          checks++;
          if (bus.wrap !== 1'b0) begin failures++; $display("[TB] FAIL scan_up_wrap_clear[%0d] got=%b exp=0", s, bus.wrap); end
        end
        if (k == 2) begin
          checks++;
          if (bus.idx !== prev) begin failures++; $display("[TB] FAIL scan_up_hold[%0d] got=%0d exp=%0d", s, bus.idx, prev); end
        end
      end
      checks++;
      if (bus.idx !== exp_idx[s]) begin failures++; $display("[TB] FAIL scan_up_idx[%0d] got=%0d exp=%0d", s, bus.idx, exp_idx[s]); end
      checks++;
      if (bus.wrap !== exp_wrap[s]) begin failures++; $display("[TB] FAIL scan_up_wrap[%0d] got=%b exp=%b", s, bus.wrap, exp_wrap[s]); end
      checks++;
      if (bus.d !== exp_d[s]) begin failures++; $display("[TB] FAIL scan_up_d[%0d] got=%h exp=%h", s, bus.d, exp_d[s]); end
      prev = exp_idx[s];
    end
  endtask

  task automatic test_scan_down();
    bus.dir = 1; bus.load = 1; bus.a = 3'd1;
    tick();
    bus.load = 0;
    repeat (4) tick();
    checks++;
    if (bus.idx !== 3'd0 || bus.wrap !== 1'b0) begin failures++; $display("[TB] FAIL scan_down_first got idx=%0d wrap=%b exp idx=0 wrap=0", bus.idx, bus.wrap); end
    repeat (4) tick();
    checks++;
    if (bus.idx !== 3'd7 || bus.wrap !== 1'b1) begin failures++; $display("[TB] FAIL scan_down_wrap got idx=%0d wrap=%b exp idx=7 wrap=1", bus.idx, bus.wrap); end
    checks++;
    if (bus.d !== 8'h80) begin failures++; $display("[TB] FAIL scan_down_d got=%h exp=%h", bus.d, 8'h80); end
    repeat (2) tick();
    bus.dir = 0;
    tick();
    checks++;
    if (bus.idx !== 3'd7) begin failures++; $display("[TB] FAIL dir_flip_hold got=%0d exp=7", bus.idx); end
    tick();
    checks++;
    if (bus.idx !== 3'd0 || bus.wrap !== 1'b1) begin failures++; $display("[TB] FAIL dir_flip_step got idx=%0d wrap=%b exp idx=0 wrap=1", bus.idx, bus.wrap); end
  endtask

  task automatic test_load_on_tick();
    repeat (3) tick();
    bus.load = 1; bus.a = 3'd3;
    tick();
    bus.load = 0;
    checks++;
    if (bus.idx !== 3'd3 || bus.wrap !== 1'b0) begin failures++; $display("[TB] FAIL load_tick got idx=%0d wrap=%b exp idx=3 wrap=0", bus.idx, bus.wrap); end
    checks++;
    if (bus.d !== 8'h08) begin failures++; $display("[TB] FAIL load_tick_d got=%h exp=%h", bus.d, 8'h08); end
    repeat (3) tick();
    checks++;
    if (bus.idx !== 3'd3) begin failures++; $display("[TB] FAIL load_tick_restart got=%0d exp=3", bus.idx); end
    tick();
    checks++;
    if (bus.idx !== 3'd4 || bus.d !== 8'h10) begin failures++; $display("[TB] FAIL load_tick_next got idx=%0d d=%h exp idx=4 d=10", bus.idx, bus.d); end
  endtask

  task automatic test_enable_pause();
    repeat (2) tick();
    bus.en = 0;
    tick();
    checks++;
    if (bus.d !== 8'h00 || bus.idx !== 3'd4) begin failures++; $display("[TB] FAIL pause_off got d=%h idx=%0d exp d=00 idx=4", bus.d, bus.idx); end
    repeat (3) tick();
    checks++;
    if (bus.d !== 8'h00 || bus.idx !== 3'd4 || bus.wrap !== 1'b0) begin failures++; $display("[TB] FAIL pause_hold got d=%h idx=%0d wrap=%b exp d=00 idx=4 wrap=0", bus.d, bus.idx, bus.wrap); end
    bus.en = 1;
    tick();
    checks++;
    if (bus.d !== 8'h10 || bus.idx !== 3'd4) begin failures++; $display("[TB] FAIL pause_resume got d=%h idx=%0d exp d=10 idx=4", bus.d, bus.idx); end
    tick();
    checks++;
    if (bus.d !== 8'h20 || bus.idx !== 3'd5) begin failures++; $display("[TB] FAIL pause_next_step got d=%h idx=%0d exp d=20 idx=5", bus.d, bus.idx); end
  endtask

  task automatic test_active_low();
    low_bus.en = 1; low_bus.mode = 0; low_bus.load = 1; low_bus.a = 3'd5;
    tick();
    low_bus.load = 0;
    checks++;
    if (low_bus.d !== 8'hDF || low_bus.idx !== 3'd5) begin failures++; $display("[TB] FAIL low_select got d=%h idx=%0d exp d=df idx=5", low_bus.d, low_bus.idx); end
    low_bus.en = 0;
    tick();
    checks++;
    if (low_bus.d !== 8'hFF) begin failures++; $display("[TB] FAIL low_disabled got=%h exp=%h", low_bus.d, 8'hFF); end
    low_bus.en = 1;
    tick();
    checks++;
    if (low_bus.d !== 8'hDF) begin failures++; $display("[TB] FAIL low_reenable got=%h exp=%h", low_bus.d, 8'hDF); end
  endtask

  task automatic test_async_reset();
    bus.dir = 0; bus.load = 1; bus.a = 3'd7;
    tick();
    bus.load = 0;
    repeat (4) tick();
    checks++;
    if (bus.wrap !== 1'b1 || bus.idx !== 3'd0) begin failures++; $display("[TB] FAIL pre_reset_wrap got wrap=%b idx=%0d exp wrap=1 idx=0", bus.wrap, bus.idx); end
    bus.load = 1; bus.a = 3'd6;
    tick();
    bus.load = 0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.d !== 8'h00 || bus.idx !== 3'd0 || bus.wrap !== 1'b0) begin failures++; $display("[TB] FAIL async_reset got d=%h idx=%0d wrap=%b exp d=00 idx=0 wrap=0", bus.d, bus.idx, bus.wrap); end
    checks++;
    if (low_bus.d !== 8'hFF) begin failures++; $display("[TB] FAIL async_reset_low got=%h exp=%h", low_bus.d, 8'hFF); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.idx !== 3'd0 || bus.d !== 8'h01) begin failures++; $display("[TB] FAIL post_reset_hold got idx=%0d d=%h exp idx=0 d=01", bus.idx, bus.d); end
    tick();
    checks++;
    if (bus.idx !== 3'd1 || bus.d !== 8'h02) begin failures++; $display("[TB] FAIL post_reset_step got idx=%0d d=%h exp idx=1 d=02", bus.idx, bus.d); end
  endtask

  initial begin
    test_reset();
    test_direct_sweep();
    test_scan_up();
    test_scan_down();
    test_load_on_tick();
    test_enable_pause();
    test_active_low();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
